// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter between IFU and LSU.
package axi_rd_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IFU  = 2'b01,
        GNT_LSU  = 2'b10
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

endpackage

// File: rtl/axi_rd_arbiter_arb_select.sv
// Picks the IDLE-state winner (LSU-first with IFU anti-starvation) and tracks starvation.
module axi_rd_arbiter_arb_select
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   arb_en_i,
    input  logic   ifu_req_i,
    input  logic   lsu_req_i,
    output grant_e winner_c
);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        winner_c = GNT_NONE;
        if (lsu_req_i && !(ifu_req_i && starved)) begin
            winner_c = GNT_LSU;
        end else if (ifu_req_i) begin
            winner_c = GNT_IFU;
        end
    end

    // Only grants actually taken in IDLE move the counter.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_en_i) begin
            if (winner_c == GNT_IFU) begin
                starve_cnt_d = '0;
            end else if (winner_c == GNT_LSU && ifu_req_i && !starved) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between IFU and LSU; one burst outstanding, grant held to rlast.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned     STARVE_MAX = 4,
    parameter int unsigned     CNT_W      = 3,
    parameter logic [ID_W-1:0] IFU_ID     = 4'd0,
    parameter logic [ID_W-1:0] LSU_ID     = 4'd1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ifu_arvalid,
    output logic               ifu_arready,
    input  logic [ADDR_W-1:0]  ifu_araddr,
    input  logic [LEN_W-1:0]   ifu_arlen,
    input  logic [SIZE_W-1:0]  ifu_arsize,
    input  logic [BURST_W-1:0] ifu_arburst,
    output logic               ifu_rvalid,
    input  logic               ifu_rready,
    output logic [DATA_W-1:0]  ifu_rdata,
    output logic [RESP_W-1:0]  ifu_rresp,
    output logic               ifu_rlast,
    input  logic               lsu_arvalid,
    output logic               lsu_arready,
    input  logic [ADDR_W-1:0]  lsu_araddr,
    input  logic [LEN_W-1:0]   lsu_arlen,
    input  logic [SIZE_W-1:0]  lsu_arsize,
    input  logic [BURST_W-1:0] lsu_arburst,
    output logic               lsu_rvalid,
    input  logic               lsu_rready,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic [RESP_W-1:0]  lsu_rresp,
    output logic               lsu_rlast,
    output logic               io_master_arvalid,
    input  logic               io_master_arready,
    output logic [ADDR_W-1:0]  io_master_araddr,
    output logic [ID_W-1:0]    io_master_arid,
    output logic [LEN_W-1:0]   io_master_arlen,
    output logic [SIZE_W-1:0]  io_master_arsize,
    output logic [BURST_W-1:0] io_master_arburst,
    input  logic               io_master_rvalid,
    output logic               io_master_rready,
    input  logic [DATA_W-1:0]  io_master_rdata,
    input  logic [RESP_W-1:0]  io_master_rresp,
    input  logic               io_master_rlast,
    input  logic [ID_W-1:0]    io_master_rid,
    output logic               rid_err_o
);

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    grant_e          winner_c;
    logic            rid_err_q, rid_err_d;
    logic            lsu_sel, ifu_sel;
    logic [ID_W-1:0] gnt_id;
    ar_req_t         ifu_ar, lsu_ar, sel_ar;

    axi_rd_arbiter_arb_select #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_sel (
        .clock     (clock),
        .reset     (reset),
        .arb_en_i  (state_q == IDLE),
        .ifu_req_i (ifu_arvalid),
        .lsu_req_i (lsu_arvalid),
        .winner_c  (winner_c)
    );

    assign lsu_sel = (grant_q == GNT_LSU);
    assign ifu_sel = (grant_q == GNT_IFU);
    assign gnt_id  = lsu_sel ? LSU_ID : IFU_ID;
    assign ifu_ar  = '{addr: ifu_araddr, len: ifu_arlen, size: ifu_arsize, burst: ifu_arburst};
    assign lsu_ar  = '{addr: lsu_araddr, len: lsu_arlen, size: lsu_arsize, burst: lsu_arburst};
    assign sel_ar  = lsu_sel ? lsu_ar : ifu_ar;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= GNT_NONE;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rid_err_q <= rid_err_d;
        end
    end

    // Next state: grant is registered in IDLE and released only on the rlast handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rid_err_d = rid_err_q;
        unique case (state_q)
            IDLE: begin
                if (winner_c != GNT_NONE) begin
                    state_d = ADDR;
                    grant_d = winner_c;
                end
            end
            ADDR: begin
                if (io_master_arvalid && io_master_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (io_master_rvalid && io_master_rready) begin
                    if (io_master_rid != gnt_id) begin
                        rid_err_d = 1'b1;
                    end
                    if (io_master_rlast) begin
                        state_d = IDLE;
                        grant_d = GNT_NONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // Channel muxes: everything not owned by the granted requester is held at 0.
    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_arid    = '0;
        io_master_arlen   = '0;
        io_master_arsize  = '0;
        io_master_arburst = '0;
        io_master_rready  = 1'b0;
        ifu_arready       = 1'b0;
        lsu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        ifu_rdata         = '0;
        ifu_rresp         = '0;
        ifu_rlast         = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_rdata         = '0;
        lsu_rresp         = '0;
        lsu_rlast         = 1'b0;
        if (state_q == ADDR && (ifu_sel || lsu_sel)) begin
            io_master_arvalid = lsu_sel ? lsu_arvalid : ifu_arvalid;
            io_master_araddr  = sel_ar.addr;
            io_master_arid    = gnt_id;
            io_master_arlen   = sel_ar.len;
            io_master_arsize  = sel_ar.size;
            io_master_arburst = sel_ar.burst;
            ifu_arready       = ifu_sel && io_master_arready;
            lsu_arready       = lsu_sel && io_master_arready;
        end
        if (state_q == DATA && ifu_sel) begin
            io_master_rready = ifu_rready;
            ifu_rvalid       = io_master_rvalid;
            ifu_rdata        = io_master_rdata;
            ifu_rresp        = io_master_rresp;
            ifu_rlast        = io_master_rlast;
        end
        if (state_q == DATA && lsu_sel) begin
            io_master_rready = lsu_rready;
            lsu_rvalid       = io_master_rvalid;
            lsu_rdata        = io_master_rdata;
            lsu_rresp        = io_master_rresp;
            lsu_rlast        = io_master_rlast;
        end
    end

    assign rid_err_o = rid_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: burst vector table, R-beat scoreboard, corner sequences.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        clock, reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready, io_master_rlast;
    logic [31:0] io_master_araddr, io_master_rdata;
    logic [3:0]  io_master_arid, io_master_rid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst, io_master_rresp;
    logic        rid_err_o;

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  rid0;
        logic [3:0]  id;
        logic        exp_err;
    } vec_t;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } sb_t;

    vec_t vecs[4];
    sb_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;

    axi_rd_arbiter dut (
        .clock (clock), .reset (reset),
        .ifu_arvalid (ifu_arvalid), .ifu_arready (ifu_arready), .ifu_araddr (ifu_araddr),
        .ifu_arlen (ifu_arlen), .ifu_arsize (ifu_arsize), .ifu_arburst (ifu_arburst),
        .ifu_rvalid (ifu_rvalid), .ifu_rready (ifu_rready), .ifu_rdata (ifu_rdata),
        .ifu_rresp (ifu_rresp), .ifu_rlast (ifu_rlast),
        .lsu_arvalid (lsu_arvalid), .lsu_arready (lsu_arready), .lsu_araddr (lsu_araddr),
        .lsu_arlen (lsu_arlen), .lsu_arsize (lsu_arsize), .lsu_arburst (lsu_arburst),
        .lsu_rvalid (lsu_rvalid), .lsu_rready (lsu_rready), .lsu_rdata (lsu_rdata),
        .lsu_rresp (lsu_rresp), .lsu_rlast (lsu_rlast),
        .io_master_arvalid (io_master_arvalid), .io_master_arready (io_master_arready),
        .io_master_araddr (io_master_araddr), .io_master_arid (io_master_arid),
        .io_master_arlen (io_master_arlen), .io_master_arsize (io_master_arsize),
        .io_master_arburst (io_master_arburst),
        .io_master_rvalid (io_master_rvalid), .io_master_rready (io_master_rready),
        .io_master_rdata (io_master_rdata), .io_master_rresp (io_master_rresp),
        .io_master_rlast (io_master_rlast), .io_master_rid (io_master_rid),
        .rid_err_o (rid_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every beat delivered to a requester must match the next one driven.
    always @(negedge clock) begin
        sb_t e;
        if (ifu_rvalid && lsu_rvalid) begin
            checks++;
            errors++;
            $display("FAIL dual_rvalid actual=both expected=one");
        end
        if ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_beat actual=beat expected=none");
            end else begin
                e = exp_q.pop_front();
                chk("sb_target", 32'(lsu_rvalid), 32'(e.lsu));
                chk("sb_data", lsu_rvalid ? lsu_rdata : ifu_rdata, e.data);
                chk("sb_resp", 32'(lsu_rvalid ? lsu_rresp : ifu_rresp), 32'(e.resp));
                chk("sb_last", 32'(lsu_rvalid ? lsu_rlast : ifu_rlast), 32'(e.last));
            end
        end
    end

    task automatic wait_ar(input bit lsu, input logic [31:0] addr, input logic [7:0] len,
                           input int exp_n, input string tag);
        int n = 0;
        io_master_arready = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!io_master_arvalid && n < 20);
        chk({tag, "_arvalid"}, 32'(io_master_arvalid), 32'd1);
        if (exp_n != 0) chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_araddr"}, io_master_araddr, addr);
        chk({tag, "_arid"}, 32'(io_master_arid), lsu ? 32'd1 : 32'd0);
        chk({tag, "_arlen"}, 32'(io_master_arlen), 32'(len));
        chk({tag, "_arsize"}, 32'(io_master_arsize), 32'd2);
        chk({tag, "_arburst"}, 32'(io_master_arburst), 32'(BURST_INCR));
        chk({tag, "_gnt_arready"}, 32'(lsu ? lsu_arready : ifu_arready), 32'd1);
        chk({tag, "_oth_arready"}, 32'(lsu ? ifu_arready : lsu_arready), 32'd0);
        @(posedge clock);
        #1;
        io_master_arready = 1'b0;
    endtask

    task automatic run_beats(input bit lsu, input logic [7:0] len, input logic [3:0] rid0,
                             input logic [3:0] id, input int nb);
        sb_t e;
        for (int b = 0; b < nb; b++) begin
            io_master_rvalid = 1'b1;
            io_master_rdata  = $urandom;
            io_master_rresp  = 2'(b);
            io_master_rlast  = (b == int'(len));
            io_master_rid    = (b == 0) ? rid0 : id;
            e.lsu  = lsu;
            e.data = io_master_rdata;
            e.resp = io_master_rresp;
            e.last = io_master_rlast;
            exp_q.push_back(e);
            @(negedge clock);
            chk("beat_other_rvalid", 32'(lsu ? ifu_rvalid : lsu_rvalid), 32'd0);
            chk("beat_arready", 32'({ifu_arready, lsu_arready}), 32'd0);
            chk("beat_rready", 32'(io_master_rready), 32'd1);
            @(posedge clock);
            #1;
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
    endtask

    initial begin
        bit order[6];
        vecs[0] = '{lsu: 1'b1, addr: 32'h0000_1000, len: 8'd3, rid0: 4'd1, id: 4'd1, exp_err: 1'b0};
        vecs[1] = '{lsu: 1'b0, addr: 32'h8000_0010, len: 8'd3, rid0: 4'd0, id: 4'd0, exp_err: 1'b0};
        vecs[2] = '{lsu: 1'b1, addr: 32'h2000_0040, len: 8'd1, rid0: 4'd2, id: 4'd1, exp_err: 1'b1};
        vecs[3] = '{lsu: 1'b0, addr: 32'h8000_0100, len: 8'd0, rid0: 4'd0, id: 4'd0, exp_err: 1'b1};
        order[0] = 1'b1; order[1] = 1'b1; order[2] = 1'b1;
        order[3] = 1'b1; order[4] = 1'b0; order[5] = 1'b1;

        reset = 1'b0;
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2; ifu_arburst = BURST_INCR;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2; lsu_arburst = BURST_INCR;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rdata = '0;
        io_master_rresp = '0; io_master_rlast = 1'b0; io_master_rid = '0;

        @(negedge clock);
        chk("rst_arvalid", 32'(io_master_arvalid), 32'd0);
        chk("rst_rready", 32'(io_master_rready), 32'd0);
        chk("rst_rid_err", 32'(rid_err_o), 32'd0);
        chk("rst_rvalids", 32'({ifu_rvalid, lsu_rvalid}), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // A stray R beat while IDLE must not reach either requester.
        io_master_rvalid = 1'b1;
        io_master_rlast  = 1'b1;
        @(negedge clock);
        chk("idle_r_ifu", 32'(ifu_rvalid), 32'd0);
        chk("idle_r_lsu", 32'(lsu_rvalid), 32'd0);
        chk("idle_rready", 32'(io_master_rready), 32'd0);
        @(posedge clock);
        #1;
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].lsu) begin
                lsu_arvalid = 1'b1; lsu_araddr = vecs[i].addr; lsu_arlen = vecs[i].len;
            end else begin
                ifu_arvalid = 1'b1; ifu_araddr = vecs[i].addr; ifu_arlen = vecs[i].len;
            end
            wait_ar(vecs[i].lsu, vecs[i].addr, vecs[i].len, 2, $sformatf("vec%0d", i));
            ifu_arvalid = 1'b0;
            lsu_arvalid = 1'b0;
            run_beats(vecs[i].lsu, vecs[i].len, vecs[i].rid0, vecs[i].id, int'(vecs[i].len) + 1);
            chk($sformatf("vec%0d_sb_empty", i), exp_q.size(), 32'd0);
            chk($sformatf("vec%0d_rid_err", i), 32'(rid_err_o), 32'(vecs[i].exp_err));
        end

        // LSU request arriving mid-IFU burst waits for the burst and the idle cycle.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0200; ifu_arlen = 8'd2;
        wait_ar(1'b0, 32'h8000_0200, 8'd2, 2, "t4_ifu");
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h3000_0000; lsu_arlen = 8'd0;
        run_beats(1'b0, 8'd2, 4'd0, 4'd0, 3);
        io_master_arready = 1'b1;
        @(negedge clock);
        chk("t4_idle_lsu_arready", 32'(lsu_arready), 32'd0);
        chk("t4_idle_arvalid", 32'(io_master_arvalid), 32'd0);
        wait_ar(1'b1, 32'h3000_0000, 8'd0, 1, "t4_lsu");
        lsu_arvalid = 1'b0;
        run_beats(1'b1, 8'd0, 4'd1, 4'd1, 1);
        chk("t4_sb_empty", exp_q.size(), 32'd0);

        // Both held: four LSU wins, then IFU is forced, then LSU again.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0300; ifu_arlen = 8'd0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h4000_0000; lsu_arlen = 8'd0;
        for (int k = 0; k < 6; k++) begin
            wait_ar(order[k], order[k] ? 32'h4000_0000 : 32'h8000_0300, 8'd0, 2,
                    $sformatf("starve%0d", k));
            run_beats(order[k], 8'd0, order[k] ? 4'd1 : 4'd0, order[k] ? 4'd1 : 4'd0, 1);
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        chk("starve_sb_empty", exp_q.size(), 32'd0);

        // Reset asserted during beat 2 of a 4-beat LSU burst.
        lsu_arvalid = 1'b1; lsu_araddr = 32'h5000_0000; lsu_arlen = 8'd3;
        wait_ar(1'b1, 32'h5000_0000, 8'd3, 2, "rst_burst");
        lsu_arvalid = 1'b0;
        run_beats(1'b1, 8'd3, 4'd1, 4'd1, 2);
        io_master_rvalid = 1'b1; io_master_rdata = 32'hDEAD_BEEF; io_master_rid = 4'd1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("mid_rst_lsu_rdata", lsu_rdata, 32'd0);
        chk("mid_rst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        chk("mid_rst_rready", 32'(io_master_rready), 32'd0);
        chk("mid_rst_arvalid", 32'(io_master_arvalid), 32'd0);
        chk("mid_rst_arready", 32'({ifu_arready, lsu_arready}), 32'd0);
        chk("mid_rst_rid_err", 32'(rid_err_o), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        io_master_rvalid = 1'b0;
        @(negedge clock);
        chk("post_rst_state", 32'(dut.state_q), 32'd0);
        chk("post_rst_starve", 32'(dut.u_sel.starve_cnt_q), 32'd0);
        chk("post_rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("post_rst_sb_empty", exp_q.size(), 32'd0);
        @(posedge clock);
        #1;

        // Normal service resumes after reset.
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0400; ifu_arlen = 8'd1;
        wait_ar(1'b0, 32'h8000_0400, 8'd1, 2, "recover");
        ifu_arvalid = 1'b0;
        run_beats(1'b0, 8'd1, 4'd0, 4'd0, 2);
        chk("recover_sb_empty", exp_q.size(), 32'd0);
        chk("recover_rid_err", 32'(rid_err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
